// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and bus-owner encodings for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way grant picker.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise data beats fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       f_req_i,
  input  logic       d_req_i,
  input  logic       last_owner_i,
  output logic [1:0] grant_o
);
`ifdef MEM_ARB_RR_EN
  // last_owner_i: 0 = fetch, 1 = data; on a tie the other side wins
  assign grant_o = (d_req_i && f_req_i) ? (last_owner_i ? OWN_FETCH : OWN_DATA) :
                   d_req_i ? OWN_DATA : f_req_i ? OWN_FETCH : OWN_NONE;
`else
  logic unused_last;
  assign unused_last = last_owner_i;
  assign grant_o = d_req_i ? OWN_DATA : f_req_i ? OWN_FETCH : OWN_NONE;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store accesses onto one single-port sync RAM.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of data-over-fetch priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner
);
  state_t        state_q;
  logic [1:0]    owner_q;
  logic          we_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          f_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] f_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          busy_q;
  logic          last_owner;
  logic [1:0]    grant;
  mem_arb_pick u_pick (
    .f_req_i      (f_req),
    .d_req_i      (d_req),
    .last_owner_i (last_owner),
    .grant_o      (grant)
  );
`ifdef MEM_ARB_RR_EN
  logic last_owner_q;
  assign last_owner = last_owner_q;
  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= 1'b0;
    else if (state_q == IDLE && grant != OWN_NONE) last_owner_q <= (grant == OWN_DATA);
  end
`else
  assign last_owner = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      we_q      <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (grant != OWN_NONE) begin
          state_q  <= GRANT;
          owner_q  <= grant;
          busy_q   <= 1'b1;
          mem_en_q <= 1'b1;
          we_q     <= (grant == OWN_DATA) && d_we;
          mem_we_q <= (grant == OWN_DATA) && d_we;
          addr_q   <= (grant == OWN_DATA) ? d_addr : f_addr;
          wdata_q  <= (grant == OWN_DATA) ? d_wdata : wdata_q;
        end
        GRANT: begin
          state_q  <= RESP;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          f_ack_q  <= (owner_q == OWN_FETCH);
          d_ack_q  <= (owner_q == OWN_DATA);
        end
        RESP: begin
          state_q   <= IDLE;
          owner_q   <= OWN_NONE;
          busy_q    <= 1'b0;
          f_rdata_q <= f_ack_q ? mem_rdata : f_rdata_q;
          d_rdata_q <= (d_ack_q && !we_q) ? mem_rdata : d_rdata_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // RAM data arrives in RESP, so it is forwarded while the ack is high and held afterwards
  assign f_rdata   = f_ack_q ? mem_rdata : f_rdata_q;
  assign d_rdata   = (d_ack_q && !we_q) ? mem_rdata : d_rdata_q;
  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of the memory port arbiter against a small sync RAM model.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [7:0]  f_addr = '0;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] ram [256];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );
  // RAM model; contents are seeded while reset is held
  always @(posedge clk) begin
    if (reset) begin
      ram[8'h00] <= 16'hA000;
      ram[8'h01] <= 16'hA001;
      ram[8'h02] <= 16'hA002;
      ram[8'h10] <= 16'hC123;
      ram[8'h30] <= 16'h5A5A;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_acks", 32'({f_ack, d_ack}), 32'h0);
    chk("rst_rdata", 32'({f_rdata, d_rdata}), 32'h0);
    reset = 1'b0;
    f_req = 1'b1; f_addr = 8'h10;
    tick;
    chk("f1_mem_en", 32'(mem_en), 32'h1);
    chk("f1_mem_we", 32'(mem_we), 32'h0);
    chk("f1_addr", 32'(mem_addr), 32'h10);
    chk("f1_owner", 32'(owner), 32'h1);
    chk("f1_busy", 32'(busy), 32'h1);
    tick;
    chk("f1_ack", 32'(f_ack), 32'h1);
    chk("f1_rdata", 32'(f_rdata), 32'hC123);
    chk("f1_mem_en_resp", 32'(mem_en), 32'h0);
    f_req = 1'b0;
    tick;
    chk("f1_owner_idle", 32'(owner), 32'h0);
    chk("f1_ack_low", 32'(f_ack), 32'h0);
    chk("f1_rdata_hold", 32'(f_rdata), 32'hC123);
    chk("f1_busy_idle", 32'(busy), 32'h0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF;
    tick;
    chk("st_mem_we", 32'(mem_we), 32'h1);
    chk("st_addr", 32'(mem_addr), 32'h20);
    chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("st_owner", 32'(owner), 32'h2);
    tick;
    chk("st_ack", 32'(d_ack), 32'h1);
    chk("st_we_resp", 32'(mem_we), 32'h0);
    chk("st_rdata_keep", 32'(d_rdata), 32'h0);
    d_req = 1'b0;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    tick;
    chk("ld_mem_we", 32'(mem_we), 32'h0);
    tick;
    chk("ld_ack", 32'(d_ack), 32'h1);
    chk("ld_rdata", 32'(d_rdata), 32'hBEEF);
    d_req = 1'b0;
    tick;
    f_req = 1'b1; f_addr = 8'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    tick;
    chk("tie_first_owner", 32'(owner), RR ? 32'h1 : 32'h2);
    tick;
    chk("tie_first_d_ack", 32'(d_ack), RR ? 32'h0 : 32'h1);
    chk("tie_first_f_ack", 32'(f_ack), RR ? 32'h1 : 32'h0);
    if (RR) f_req = 1'b0; else d_req = 1'b0;
    tick;
    chk("tie_gap_owner", 32'(owner), 32'h0);
    tick;
    chk("tie_second_owner", 32'(owner), RR ? 32'h2 : 32'h1);
    tick;
    chk("tie_second_d_ack", 32'(d_ack), RR ? 32'h1 : 32'h0);
    chk("tie_second_f_ack", 32'(f_ack), RR ? 32'h0 : 32'h1);
    f_req = 1'b0; d_req = 1'b0;
    tick;
    chk("tie_f_rdata", 32'(f_rdata), 32'hC123);
    chk("tie_d_rdata", 32'(d_rdata), 32'hBEEF);
    f_req = 1'b1; f_addr = 8'h01;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
    chk("late_owner_f", 32'(owner), 32'h1);
    tick;
    chk("late_f_ack", 32'(f_ack), 32'h1);
    chk("late_f_rdata", 32'(f_rdata), 32'hA001);
    chk("late_no_d_ack", 32'(d_ack), 32'h0);
    f_req = 1'b0;
    tick;
    chk("late_idle_d_ack", 32'(d_ack), 32'h0);
    tick;
    chk("late_owner_d", 32'(owner), 32'h2);
    chk("late_addr", 32'(mem_addr), 32'h30);
    tick;
    chk("late_d_ack", 32'(d_ack), 32'h1);
    chk("late_d_rdata", 32'(d_rdata), 32'h5A5A);
    d_req = 1'b0;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    tick;
    chk("abort_mem_en", 32'(mem_en), 32'h1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_no_ack", 32'(d_ack), 32'h0);
    chk("abort_mem", 32'({mem_en, mem_we}), 32'h0);
    chk("abort_owner", 32'(owner), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_addr", 32'(mem_addr), 32'h0);
    chk("abort_rdata", 32'({f_rdata, d_rdata}), 32'h0);
    tick;
    chk("retry_owner", 32'(owner), 32'h2);
    chk("retry_mem_en", 32'(mem_en), 32'h1);
    tick;
    chk("retry_ack", 32'(d_ack), 32'h1);
    chk("retry_rdata", 32'(d_rdata), 32'hBEEF);
    d_req = 1'b0;
    tick;
    f_req = 1'b1; f_addr = 8'h00;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tick;
        chk("b2b_gap_idle", 32'(f_ack), 32'h0);
      end
      tick;
      chk("b2b_gap_grant", 32'(f_ack), 32'h0);
      chk("b2b_no_we", 32'(mem_we), 32'h0);
      tick;
      chk("b2b_ack", 32'(f_ack), 32'h1);
      chk("b2b_rdata", 32'(f_rdata), 32'hA000 + 32'(k));
      if (k < 2) f_addr = 8'(k + 1);
      else f_req = 1'b0;
    end
    tick;
    chk("b2b_done_owner", 32'(owner), 32'h0);
    repeat (2) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters of the RISC-16 multi-cycle core: the instruction-fetch path and the LOAD/STORE data path.
- Serialises accesses with a small FSM and returns read data with a one-cycle acknowledge pulse.
- Sits between the control-unit-driven datapath and the unified program/data memory.
- Default policy is fixed priority, with data over fetch.

Parameters:
- AW, 8, RAM address width in bits.
- DW, 16, RAM data width in bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held high until f_ack
- f_addr  in  AW  fetch address; stable while f_req high
- f_ack  out  1  one-cycle pulse; f_rdata valid this cycle
- f_rdata  out  DW  instruction word
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req high
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse; load data valid / store complete
- d_rdata  out  DW  load data
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en
- busy  out  1  high in GRANT or RESP
- owner  out  2  00 none, 01 fetch, 10 data

Behaviour:
- Reset values, applied synchronously: state=IDLE, owner=00, all mem_* and ack outputs 0, f_rdata/d_rdata=0, busy=0.
- States: IDLE -> GRANT -> RESP -> IDLE.
- IDLE:
  - If d_req is high, latch d_addr, d_we and d_wdata, set owner=10, go to GRANT.
  - Otherwise, if f_req is high, latch f_addr with we=0, set owner=01, go to GRANT.
  - Otherwise remain in IDLE.
  - The request is sampled only in IDLE.
- GRANT: mem_en=1; mem_we, mem_addr and mem_wdata are driven from the latched values. Go to RESP.
- RESP:
  - mem_en=0.
  - Pulse the owner's ack.
  - For a load or fetch, register mem_rdata into the owner's rdata; rdata holds until the next response for that owner.
  - For a store, rdata is unchanged.
  - Go to IDLE and set owner=00.
- Latency: a request first high in cycle N gets its ack in cycle N+2 when the arbiter is idle. Sustained throughput is one access per 3 cycles.
- Requesters drop req on the clock edge that samples ack. A req still high in IDLE is treated as a new request.
- Simultaneous d_req and f_req: data wins, and fetch waits in IDLE for the next decision. With fixed priority, fetch cannot starve, because the core never issues d_req back-to-back without a fetch.
- A req that rises while in GRANT or RESP is not lost; it is serviced from IDLE.
- mem_we is never high when owner=01.
- Reset in GRANT or RESP aborts the access: no ack is issued, and mem_en/mem_we are 0 from the next cycle.
- A write already issued in GRANT is not rolled back.
- Address and data widths pass through unchanged, with no truncation or extension.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_owner register resets to fetch.
  - On a tie in IDLE, grant the requester that was not last_owner; update last_owner on each grant.
  - A lone request is granted immediately.
- Undefined: fixed priority, data over fetch; no last_owner register.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding: IDLE=2'd0, GRANT=2'd1, RESP=2'd2;
  - the owner encoding: OWN_NONE=2'b00, OWN_FETCH=2'b01, OWN_DATA=2'b10.
- One natural sub-module: mem_arb_pick. It is a combinational two-way picker that takes f_req, d_req and last_owner, and outputs the grant owner. It contains the only MEM_ARB_RR_EN-dependent logic.

Test Plan:
- Reset, then f_req=1, f_addr=8'h10, RAM[0x10]=16'hC123 -> mem_en high in cycle 1; f_ack pulse in cycle 2 with f_rdata=16'hC123; owner back to 00 in cycle 3.
- d_req=1, d_we=1, d_addr=8'h20, d_wdata=16'hBEEF -> mem_we=1 in GRANT; d_ack in cycle 2; a subsequent load from 0x20 returns 16'hBEEF.
- f_req and d_req both asserted in the same cycle -> data is served first (d_ack at +2) and fetch second (f_ack at +5). With MEM_ARB_RR_EN and last_owner=data, fetch is served first instead.
- d_req rises during a fetch's GRANT -> fetch completes undisturbed; data is granted from the following IDLE; its ack comes 3 cycles after f_ack.
- reset asserted in GRANT of a load -> no d_ack, and all outputs are 0 on the next cycle. Re-asserting d_req then completes normally.
- Back-to-back fetches at 0x00, 0x01, 0x02 with req dropped on each ack -> three acks spaced exactly 3 cycles apart, with correct data each time.
